// File: rtl/gmux_pkg.sv
// Shared types and constants for the GMUX select sequencer.
package gmux_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GATE   = 3'd1,
    ST_SWITCH = 3'd2,
    ST_SETTLE = 3'd3,
    ST_ENABLE = 3'd4
  } gmux_state_e;

  localparam logic SEL_IP = 1'b0;
  localparam logic SEL_IC = 1'b1;

  localparam int DEF_GATE_CYCLES   = 4;
  localparam int DEF_SETTLE_CYCLES = 8;

  // Wide enough to hold the larger of the two wait loads, plus one bit of headroom.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    if (m < 1) m = 1;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/gmux_wait_counter.sv
// Loadable down-counter with zero flag; shared by the gate and settle waits.
module gmux_wait_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/gmux_sel_sequencer.sv
// Sequences GMUX IS0 changes: gate consumers, flip select, settle, re-enable.
module gmux_sel_sequencer
  import gmux_pkg::*;
#(
  parameter int   GATE_CYCLES   = DEF_GATE_CYCLES,
  parameter int   SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter logic RESET_SEL     = SEL_IP
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  input  logic req_sel,
  output logic req_ready,
  output logic is0,
  output logic clk_en,
  output logic busy,
  output logic done
);

  localparam int CNT_W = cnt_width(GATE_CYCLES, SETTLE_CYCLES);

  if (GATE_CYCLES < 1) begin : g_bad_gate
    $error("GATE_CYCLES must be at least 1");
  end
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("SETTLE_CYCLES must be at least 1");
  end

  gmux_state_e        state, state_d;
  logic               sel_q, sel_d;
  logic               is0_d, clk_en_d, done_d;
  logic               cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0]   cnt_val;

  gmux_wait_counter #(.W(CNT_W)) u_wait (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  // Next-state logic; same-select requests complete without leaving IDLE
  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE:   if (req_valid && (req_sel != is0)) state_d = ST_GATE;
      ST_GATE:   if (cnt_zero) state_d = ST_SWITCH;
      ST_SWITCH: state_d = ST_SETTLE;
      ST_SETTLE: if (cnt_zero) state_d = ST_ENABLE;
      ST_ENABLE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Next values for the registered outputs and counter controls
  always_comb begin
    is0_d    = is0;
    clk_en_d = clk_en;
    done_d   = 1'b0;
    sel_d    = sel_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_sel == is0) begin
            done_d = 1'b1;
          end else begin
            sel_d    = req_sel;
            clk_en_d = 1'b0;
            cnt_load = 1'b1;
            cnt_val  = CNT_W'(GATE_CYCLES - 1);
          end
        end
      end
      ST_GATE: begin
        clk_en_d = 1'b0;
        cnt_dec  = 1'b1;
      end
      ST_SWITCH: begin
        is0_d    = sel_q;
        clk_en_d = 1'b0;
        cnt_load = 1'b1;
        cnt_val  = CNT_W'(SETTLE_CYCLES - 1);
      end
      ST_SETTLE: begin
        clk_en_d = 1'b0;
        cnt_dec  = 1'b1;
      end
      ST_ENABLE: begin
        clk_en_d = 1'b1;
        done_d   = 1'b1;
      end
      default: begin
        clk_en_d = 1'b1;
      end
    endcase
  end

  // Output registers; reset wins over any in-flight sequence
  always_ff @(posedge clk) begin
    if (rst) begin
      is0    <= RESET_SEL;
      clk_en <= 1'b1;
      done   <= 1'b0;
      sel_q  <= RESET_SEL;
    end else begin
      is0    <= is0_d;
      clk_en <= clk_en_d;
      done   <= done_d;
      sel_q  <= sel_d;
    end
  end

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_gmux_sel_sequencer.sv
// Directed and randomized checks of the GMUX select sequencer at default parameters.
module tb_gmux_sel_sequencer;

  localparam int GATE = 4;

  logic clk = 1'b0;
  logic rst, req_valid, req_sel;
  logic req_ready, is0, clk_en, busy, done;

  int n_checks = 0;
  int n_pass   = 0;

  // monitor state for the random run
  logic prev_is0, prev_clk_en;
  int   low_cnt;

  always #5 clk = ~clk;

  gmux_sel_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_sel   (req_sel),
    .req_ready (req_ready),
    .is0       (is0),
    .clk_en    (clk_en),
    .busy      (busy),
    .done      (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_sel = 1'b0;
    tick(); tick();
    rst = 1'b0;
    n_checks++; if (is0 !== 1'b0) $display("FAIL reset_is0: got %b want 0", is0); else n_pass++;
    n_checks++; if (clk_en !== 1'b1) $display("FAIL reset_clk_en: got %b want 1", clk_en); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", req_ready); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
  endtask

  task automatic test_same_sel();
    req_valid = 1'b1; req_sel = 1'b0;
    tick();
    req_valid = 1'b0;
    n_checks++; if (done !== 1'b1) $display("FAIL same_done: got %b want 1", done); else n_pass++;
    n_checks++; if (clk_en !== 1'b1) $display("FAIL same_clk_en: got %b want 1", clk_en); else n_pass++;
    n_checks++; if (is0 !== 1'b0) $display("FAIL same_is0: got %b want 0", is0); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL same_busy: got %b want 0", busy); else n_pass++;
    tick();
    n_checks++; if (done !== 1'b0) $display("FAIL same_done_pulse: got %b want 0", done); else n_pass++;
    n_checks++; if (clk_en !== 1'b1) $display("FAIL same_clk_en2: got %b want 1", clk_en); else n_pass++;
  endtask

  // 0->1 switch: after accept edge e=0, is0 flips at edge 5, clk_en/done rise at edge 14
  task automatic test_switch();
    req_valid = 1'b1; req_sel = 1'b1;
    tick();
    req_valid = 1'b0;
    n_checks++; if (clk_en !== 1'b0) $display("FAIL sw_gate_e0: got %b want 0", clk_en); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL sw_busy_e0: got %b want 1", busy); else n_pass++;
    n_checks++; if (req_ready !== 1'b0) $display("FAIL sw_ready_e0: got %b want 0", req_ready); else n_pass++;
    for (int e = 1; e <= 14; e++) begin
      tick();
      n_checks++;
      if (is0 !== (e >= 5)) $display("FAIL sw_is0 e=%0d: got %b want %b", e, is0, (e >= 5));
      else n_pass++;
      n_checks++;
      if (clk_en !== (e >= 14)) $display("FAIL sw_clk_en e=%0d: got %b want %b", e, clk_en, (e >= 14));
      else n_pass++;
      n_checks++;
      if (done !== (e == 14)) $display("FAIL sw_done e=%0d: got %b want %b", e, done, (e == 14));
      else n_pass++;
    end
    tick();
    n_checks++; if (done !== 1'b0) $display("FAIL sw_done_pulse: got %b want 0", done); else n_pass++;
  endtask

  // 1->0 switch with a 0->1 request held from edge 3; accepted at edge 15, done at 29
  task automatic test_back_to_back();
    int waited;
    req_valid = 1'b1; req_sel = 1'b0;
    tick();
    req_valid = 1'b0;
    tick(); tick();
    req_valid = 1'b1; req_sel = 1'b1;
    for (int e = 3; e <= 14; e++) begin
      tick();
      n_checks++;
      if (req_ready !== (e == 14)) $display("FAIL b2b_ready e=%0d: got %b want %b", e, req_ready, (e == 14));
      else n_pass++;
      n_checks++;
      if (done !== (e == 14)) $display("FAIL b2b_done e=%0d: got %b want %b", e, done, (e == 14));
      else n_pass++;
      n_checks++;
      if (is0 !== (e < 5)) $display("FAIL b2b_is0 e=%0d: got %b want %b", e, is0, (e < 5));
      else n_pass++;
    end
    tick();
    req_valid = 1'b0;
    n_checks++; if (busy !== 1'b1) $display("FAIL b2b_accept_busy: got %b want 1", busy); else n_pass++;
    n_checks++; if (clk_en !== 1'b0) $display("FAIL b2b_accept_gate: got %b want 0", clk_en); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL b2b_accept_done: got %b want 0", done); else n_pass++;
    waited = 0;
    do begin
      tick();
      waited++;
    end while (done !== 1'b1 && waited < 30);
    n_checks++; if (waited != 14) $display("FAIL b2b_latency: got %0d want 14", waited); else n_pass++;
    n_checks++; if (is0 !== 1'b1) $display("FAIL b2b_final_is0: got %b want 1", is0); else n_pass++;
  endtask

  // Reset at edge 8 of a 0->1 switch (inside SETTLE)
  task automatic test_reset_mid_settle();
    int pulses;
    rst = 1'b1; tick(); rst = 1'b0;
    n_checks++; if (is0 !== 1'b0) $display("FAIL mid_pre_is0: got %b want 0", is0); else n_pass++;
    req_valid = 1'b1; req_sel = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int e = 1; e <= 7; e++) tick();
    n_checks++; if (is0 !== 1'b1) $display("FAIL mid_settle_is0: got %b want 1", is0); else n_pass++;
    n_checks++; if (clk_en !== 1'b0) $display("FAIL mid_settle_gate: got %b want 0", clk_en); else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (is0 !== 1'b0) $display("FAIL mid_rst_is0: got %b want 0", is0); else n_pass++;
    n_checks++; if (clk_en !== 1'b1) $display("FAIL mid_rst_clk_en: got %b want 1", clk_en); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL mid_rst_ready: got %b want 1", req_ready); else n_pass++;
    pulses = (done === 1'b1) ? 1 : 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    n_checks++; if (pulses != 0) $display("FAIL mid_rst_done_pulses: got %0d want 0", pulses); else n_pass++;
  endtask

  // Advance one cycle and check that any is0 change was properly gated
  task automatic tick_mon();
    tick();
    if (is0 !== prev_is0) begin
      n_checks++;
      if (prev_clk_en !== 1'b0 || low_cnt < GATE || clk_en !== 1'b0)
        $display("FAIL inv_gated_switch: clk_en prev=%b now=%b low_cycles=%0d want 0/0/>=%0d",
                 prev_clk_en, clk_en, low_cnt, GATE);
      else n_pass++;
    end
    if (clk_en === 1'b0) low_cnt++;
    else low_cnt = 0;
    prev_is0    = is0;
    prev_clk_en = clk_en;
  endtask

  task automatic test_random();
    logic target;
    int   waited;
    prev_is0 = is0; prev_clk_en = clk_en; low_cnt = 0;
    for (int r = 0; r < 1000; r++) begin
      target    = 1'($urandom_range(0, 1));
      req_valid = 1'b1;
      req_sel   = target;
      waited    = 0;
      do begin
        tick_mon();
        req_valid = 1'b0;
        waited++;
      end while (done !== 1'b1 && waited < 40);
      n_checks++;
      if (done !== 1'b1 || is0 !== target)
        $display("FAIL rnd_req %0d: done=%b is0=%b want done=1 is0=%b", r, done, is0, target);
      else n_pass++;
      repeat ($urandom_range(0, 2)) tick_mon();
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_sel = 1'b0;
    test_reset();
    test_same_sel();
    test_switch();
    test_back_to_back();
    test_reset_mid_settle();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
